// File: rtl/bus_timer_if.sv
// Bus device handshake between the system bus and the machine timer:
// one-cycle request pulse in, registered response one cycle later.
interface bus_timer_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic                    timer_req_i;
  logic                    timer_we_i;
  logic [3:0]              timer_be_i;
  logic [AddressWidth-1:0] timer_addr_i;
  logic [DataWidth-1:0]    timer_wdata_i;
  logic                    timer_rvalid_o;
  logic [DataWidth-1:0]    timer_rdata_o;
  logic                    timer_err_o;

  modport master (
    output timer_req_i, timer_we_i, timer_be_i, timer_addr_i, timer_wdata_i,
    input  timer_rvalid_o, timer_rdata_o, timer_err_o
  );

  modport slave (
    input  timer_req_i, timer_we_i, timer_be_i, timer_addr_i, timer_wdata_i,
    output timer_rvalid_o, timer_rdata_o, timer_err_o
  );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp
// and a registered level interrupt, behind a single-cycle bus device port.
module bus_timer #(
  parameter int          DataWidth     = 32,
  parameter int          AddressWidth  = 32,
  parameter logic [15:0] PrescaleReset = 16'd0
) (
  input  logic        CLK,
  input  logic        RST,
  bus_timer_if.slave  bus,
  output logic        timer_intr_o
);

  localparam logic [9:0] OFF_MTIME_LO    = 10'h000;
  localparam logic [9:0] OFF_MTIME_HI    = 10'h001;
  localparam logic [9:0] OFF_MTIMECMP_LO = 10'h002;
  localparam logic [9:0] OFF_MTIMECMP_HI = 10'h003;
  localparam logic [9:0] OFF_PRESCALE    = 10'h004;
  localparam logic [9:0] OFF_CTRL        = 10'h005;

  logic [63:0]          r_mtime;
  logic [63:0]          r_mtimecmp;
  logic [15:0]          r_prescale;
  logic [15:0]          r_pcnt;
  logic                 r_en;
  logic                 r_irq_en;
  logic                 r_rvalid;
  logic                 r_err;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_intr;

  logic [9:0]           w_off;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_mapped;
  logic                 w_tick;
  logic                 w_wr_mlo;
  logic                 w_wr_mhi;
  logic                 w_wr_clo;
  logic                 w_wr_chi;
  logic                 w_wr_ps;
  logic                 w_wr_ctrl;
  logic [63:0]          w_mtime_inc;
  logic [63:0]          w_mtime_nxt;
  logic [31:0]          w_wdata;
  logic [3:0]           w_be;
  logic [DataWidth-1:0] w_rdata;
  logic                 w_unused_addr;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  assign w_off         = bus.timer_addr_i[11:2];
  assign w_unused_addr = ^{bus.timer_addr_i[AddressWidth-1:12], bus.timer_addr_i[1:0]};
  assign w_wdata       = bus.timer_wdata_i[31:0];
  assign w_be          = bus.timer_be_i;
  assign w_wr          = bus.timer_req_i & bus.timer_we_i;
  assign w_rd          = bus.timer_req_i & ~bus.timer_we_i;
  assign w_mapped      = (w_off <= OFF_CTRL);

  assign w_wr_mlo  = w_wr & (w_off == OFF_MTIME_LO);
  assign w_wr_mhi  = w_wr & (w_off == OFF_MTIME_HI);
  assign w_wr_clo  = w_wr & (w_off == OFF_MTIMECMP_LO);
  assign w_wr_chi  = w_wr & (w_off == OFF_MTIMECMP_HI);
  assign w_wr_ps   = w_wr & (w_off == OFF_PRESCALE);
  assign w_wr_ctrl = w_wr & (w_off == OFF_CTRL);

  assign w_tick      = r_en & (r_pcnt == r_prescale);
  assign w_mtime_inc = r_mtime + {63'd0, w_tick};

  // Software bytes win over the tick; everything else, carry included,
  // follows the incremented count.
  always_comb begin
    w_mtime_nxt = w_mtime_inc;
    if (w_wr_mlo) w_mtime_nxt[31:0]  = merge_be(w_mtime_inc[31:0], w_wdata, w_be);
    if (w_wr_mhi) w_mtime_nxt[63:32] = merge_be(w_mtime_inc[63:32], w_wdata, w_be);
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_MTIME_LO:    w_rdata = r_mtime[31:0];
      OFF_MTIME_HI:    w_rdata = r_mtime[63:32];
      OFF_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      OFF_PRESCALE:    w_rdata = {16'd0, r_prescale};
      OFF_CTRL:        w_rdata = {30'd0, r_irq_en, r_en};
      default:         w_rdata = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      r_mtime <= w_mtime_nxt;
      if (w_wr_clo) r_mtimecmp[31:0]  <= merge_be(r_mtimecmp[31:0], w_wdata, w_be);
      if (w_wr_chi) r_mtimecmp[63:32] <= merge_be(r_mtimecmp[63:32], w_wdata, w_be);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prescale <= PrescaleReset;
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
    end else begin
      if (w_wr_ps & w_be[0]) r_prescale[7:0]  <= w_wdata[7:0];
      if (w_wr_ps & w_be[1]) r_prescale[15:8] <= w_wdata[15:8];
      if (w_wr_ctrl & w_be[0]) begin
        r_en     <= w_wdata[0];
        r_irq_en <= w_wdata[1];
      end
    end
  end

  // Reprogramming the rate or enable restarts the prescale period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pcnt <= '0;
    end else if (w_wr_ps | w_wr_ctrl) begin
      r_pcnt <= '0;
    end else if (r_en) begin
      r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_intr   <= 1'b0;
    end else begin
      r_rvalid <= bus.timer_req_i;
      r_err    <= bus.timer_req_i & ~w_mapped;
      r_rdata  <= w_rd ? w_rdata : '0;
      r_intr   <= r_irq_en & (r_mtime >= r_mtimecmp);
    end
  end

  assign bus.timer_rvalid_o = r_rvalid;
  assign bus.timer_rdata_o  = r_rdata;
  assign bus.timer_err_o    = r_err;
  assign timer_intr_o       = r_intr;

endmodule
